// File: rtl/exc_irq_ctrl.sv
// exc_irq_ctrl: exception / interrupt request controller.
// Latches rising edges on the external IRQ lines, arbitrates invalid-opcode
// traps against pending interrupts, and handshakes with the datapath through
// the IDLE -> RAISE -> SERVICE sequence.
// Optional feature: define IRQ_MASK_EN to add a writable per-channel mask.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no exception in flight, arbitrating trap vs pending IRQs
//   RAISE   | exc asserted, waiting for the datapath to take the vector
//   SERVICE | handler running, waiting for ERET
module exc_irq_ctrl #(
  parameter int N_IRQ = 4,
  parameter int ID_W  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq,
  input  logic             not_an_instr,
  input  logic             exc_ack,
  input  logic             eret,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  output logic             exc,
  output logic [3:0]       estatus,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_IRQ-1:0] irq_ack,
  output logic             double_fault,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_RAISE, S_SERVICE} state_t;

  localparam logic [3:0]       ST_NONE  = 4'b0000;
  localparam logic [3:0]       ST_IRQ   = 4'b0001;
  localparam logic [3:0]       ST_INSTR = 4'b0010;
  localparam logic [N_IRQ-1:0] ONE      = 1;

  state_t           state_q, state_d;
  logic             exc_q, exc_d;
  logic [3:0]       estatus_q, estatus_d;
  logic [ID_W-1:0]  irq_id_q, irq_id_d;
  logic [N_IRQ-1:0] irq_ack_q, irq_ack_d;
  logic             double_fault_q, double_fault_d;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] irq_q;
  logic [N_IRQ-1:0] mask;
  logic [N_IRQ-1:0] eligible;
  logic [ID_W-1:0]  lowest_id;
  logic             found;

`ifdef IRQ_MASK_EN
  logic [N_IRQ-1:0] mask_q, mask_d;

  // Mask register; a write takes effect on the cycle after the strobe.
  always_comb begin
    mask_d = mask_we ? mask_wdata : mask_q;
  end

  // Mask storage.
  always_ff @(posedge clk) begin
    if (reset) mask_q <= '0;
    else       mask_q <= mask_d;
  end

  assign mask = mask_q;
`else
  logic unused_mask_inputs;
  assign unused_mask_inputs = &{1'b0, mask_we, mask_wdata};
  assign mask = '0;
`endif

  // Previous IRQ levels. Sampled even during reset so a line held high
  // across reset is seen as a level, not a fresh edge, once reset drops.
  always_ff @(posedge clk) begin
    irq_q <= irq;
  end

  // Pending latch, lowest-index arbitration and next-state logic.
  always_comb begin
    // A new edge on the channel being acknowledged keeps the bit set.
    pending_d = (pending_q & ~irq_ack_q) | (irq & ~irq_q);
    eligible  = pending_q & ~mask;
    lowest_id = '0;
    found     = 1'b0;
    for (int k = 0; k < N_IRQ; k++) begin
      if (eligible[k] && !found) begin
        lowest_id = ID_W'(k);
        found     = 1'b1;
      end
    end

    state_d        = state_q;
    exc_d          = exc_q;
    estatus_d      = estatus_q;
    irq_id_d       = irq_id_q;
    irq_ack_d      = '0;
    double_fault_d = double_fault_q;

    case (state_q)
      S_IDLE: begin
        if (not_an_instr) begin
          state_d   = S_RAISE;
          exc_d     = 1'b1;
          estatus_d = ST_INSTR;
          irq_id_d  = '0;
        end else if (found) begin
          state_d   = S_RAISE;
          exc_d     = 1'b1;
          estatus_d = ST_IRQ;
          irq_id_d  = lowest_id;
        end
      end
      S_RAISE: begin
        if (exc_ack) begin
          state_d = S_SERVICE;
          exc_d   = 1'b0;
          if (estatus_q == ST_IRQ) irq_ack_d = ONE << irq_id_q;
        end
      end
      S_SERVICE: begin
        if (not_an_instr) double_fault_d = 1'b1;
        if (eret) begin
          state_d   = S_IDLE;
          estatus_d = ST_NONE;
          irq_id_d  = '0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        exc_d     = 1'b0;
        estatus_d = ST_NONE;
        irq_id_d  = '0;
      end
    endcase
  end

  // FSM state, registered outputs and pending bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      exc_q          <= 1'b0;
      estatus_q      <= ST_NONE;
      irq_id_q       <= '0;
      irq_ack_q      <= '0;
      double_fault_q <= 1'b0;
      pending_q      <= '0;
    end else begin
      state_q        <= state_d;
      exc_q          <= exc_d;
      estatus_q      <= estatus_d;
      irq_id_q       <= irq_id_d;
      irq_ack_q      <= irq_ack_d;
      double_fault_q <= double_fault_d;
      pending_q      <= pending_d;
    end
  end

  assign exc          = exc_q;
  assign estatus      = estatus_q;
  assign irq_id       = irq_id_q;
  assign irq_ack      = irq_ack_q;
  assign double_fault = double_fault_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_exc_irq_ctrl.sv
// tb_exc_irq_ctrl: directed stimulus with a scoreboard. Stimulus pushes the
// expected exception (cause, id, cycle of exc rise) and expected irq_ack
// pulses; a negedge monitor pops and compares whenever the DUT presents them.
module tb_exc_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] irq = '0;
  logic       not_an_instr = 1'b0;
  logic       exc_ack = 1'b0;
  logic       eret = 1'b0;
  logic       mask_we = 1'b0;
  logic [3:0] mask_wdata = '0;
  logic       exc;
  logic [3:0] estatus;
  logic [1:0] irq_id;
  logic [3:0] irq_ack;
  logic       double_fault;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {logic [3:0] st; logic [1:0] id; int cyc;} exc_exp_t;
  typedef struct {logic [3:0] v; int cyc;} ack_exp_t;
  exc_exp_t exc_sb[$];
  ack_exp_t ack_sb[$];

  exc_irq_ctrl #(.N_IRQ(4), .ID_W(2)) dut (
    .clk(clk), .reset(reset), .irq(irq), .not_an_instr(not_an_instr),
    .exc_ack(exc_ack), .eret(eret), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .exc(exc), .estatus(estatus), .irq_id(irq_id), .irq_ack(irq_ack),
    .double_fault(double_fault), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every exc rise and every irq_ack pulse against the scoreboard.
  logic exc_prev = 1'b0;
  always @(negedge clk) begin
    if (exc === 1'b1 && exc_prev !== 1'b1) begin
      tests++;
      if (exc_sb.size() == 0) begin
        fails++;
        $display("FAIL exc_unexpected: exc rose at cycle %0d st=%0h id=%0d, none expected", cyc, estatus, irq_id);
      end else begin
        exc_exp_t e;
        e = exc_sb.pop_front();
        if (estatus !== e.st || irq_id !== e.id || cyc != e.cyc) begin
          fails++;
          $display("FAIL exc_rise: got st=%0h id=%0d cyc=%0d expected st=%0h id=%0d cyc=%0d",
                   estatus, irq_id, cyc, e.st, e.id, e.cyc);
        end
      end
    end
    exc_prev = exc;
    if (irq_ack !== 4'b0000) begin
      tests++;
      if (ack_sb.size() == 0) begin
        fails++;
        $display("FAIL ack_unexpected: irq_ack=%b at cycle %0d, none expected", irq_ack, cyc);
      end else begin
        ack_exp_t a;
        a = ack_sb.pop_front();
        if (irq_ack !== a.v || cyc != a.cyc) begin
          fails++;
          $display("FAIL irq_ack: got %b cyc=%0d expected %b cyc=%0d", irq_ack, cyc, a.v, a.cyc);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exc(input logic [3:0] st, input logic [1:0] id, input int c);
    exc_exp_t e;
    e.st = st; e.id = id; e.cyc = c;
    exc_sb.push_back(e);
  endtask

  task automatic wait_exc();
    int n = 0;
    while (exc !== 1'b1 && n < 50) begin
      tick(1);
      n++;
    end
    chk("exc_wait_timeout", {31'd0, exc}, 32'd1);
  endtask

  // Take the pending exception, acknowledge it, run the handler, ERET.
  task automatic service(input logic [3:0] ack, output int e_cyc);
    ack_exp_t a;
    wait_exc();
    exc_ack = 1'b1;
    if (ack != 4'b0000) begin
      a.v = ack; a.cyc = cyc + 1;
      ack_sb.push_back(a);
    end
    tick(1);
    exc_ack = 1'b0;
    chk("service_exc_low", {31'd0, exc}, 32'd0);
    chk("service_busy", {31'd0, busy}, 32'd1);
    tick(2);
    eret = 1'b1;
    e_cyc = cyc;
    tick(1);
    eret = 1'b0;
  endtask

  initial begin
    int c;
    int e;
    logic seen;
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    int e;
    logic seen;

    // Reset state.
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("rst_exc", {31'd0, exc}, 32'd0);
    chk("rst_estatus", {28'd0, estatus}, 32'd0);
    chk("rst_irq_id", {30'd0, irq_id}, 32'd0);
    chk("rst_irq_ack", {28'd0, irq_ack}, 32'd0);
    chk("rst_double_fault", {31'd0, double_fault}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // Single IRQ on channel 2, two-cycle latency.
    c = cyc;
    irq = 4'b0100;
    push_exc(4'b0001, 2'd2, c + 2);
    wait_exc();
    chk("irq2_busy", {31'd0, busy}, 32'd1);
    service(4'b0100, e);
    chk("irq2_estatus_cleared", {28'd0, estatus}, 32'd0);
    chk("irq2_idle", {31'd0, busy}, 32'd0);
    irq = 4'b0000;
    tick(2);

    // Simultaneous IRQ 1 and 3: lowest first, second after ERET.
    c = cyc;
    irq = 4'b1010;
    push_exc(4'b0001, 2'd1, c + 2);
    service(4'b0010, e);
    push_exc(4'b0001, 2'd3, e + 2);
    service(4'b1000, e);
    irq = 4'b0000;
    tick(2);

    // Invalid opcode beats a same-cycle IRQ 0 edge.
    c = cyc;
    not_an_instr = 1'b1;
    irq = 4'b0001;
    push_exc(4'b0010, 2'd0, c + 1);
    tick(1);
    not_an_instr = 1'b0;
    service(4'b0000, e);
    push_exc(4'b0001, 2'd0, e + 2);
    service(4'b0001, e);
    irq = 4'b0000;
    tick(2);

    // Double fault in SERVICE, plus an IRQ edge that must wait for ERET.
    c = cyc;
    not_an_instr = 1'b1;
    push_exc(4'b0010, 2'd0, c + 1);
    tick(1);
    not_an_instr = 1'b0;
    wait_exc();
    exc_ack = 1'b1;
    tick(1);
    exc_ack = 1'b0;
    irq = 4'b0100;
    not_an_instr = 1'b1;
    tick(1);
    not_an_instr = 1'b0;
    chk("df_set", {31'd0, double_fault}, 32'd1);
    chk("df_still_service", {31'd0, busy}, 32'd1);
    chk("df_exc_low", {31'd0, exc}, 32'd0);
    chk("df_estatus_held", {28'd0, estatus}, 32'h2);
    tick(3);
    eret = 1'b1;
    push_exc(4'b0001, 2'd2, cyc + 2);
    tick(1);
    eret = 1'b0;
    service(4'b0100, e);
    irq = 4'b0000;
    tick(3);
    chk("df_sticky", {31'd0, double_fault}, 32'd1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    chk("df_cleared_by_reset", {31'd0, double_fault}, 32'd0);

    // exc_ack and eret in IDLE are ignored.
    exc_ack = 1'b1;
    eret = 1'b1;
    tick(1);
    exc_ack = 1'b0;
    eret = 1'b0;
    tick(1);
    chk("idle_ack_ignored_busy", {31'd0, busy}, 32'd0);
    chk("idle_ack_ignored_exc", {31'd0, exc}, 32'd0);

`ifdef IRQ_MASK_EN
    // Masked channel 1 stays pending until the mask is cleared.
    mask_we = 1'b1;
    mask_wdata = 4'b0010;
    tick(1);
    mask_we = 1'b0;
    irq = 4'b0010;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      seen = seen | exc;
    end
    chk("mask_blocks", {31'd0, seen}, 32'd0);
    c = cyc;
    mask_we = 1'b1;
    mask_wdata = 4'b0000;
    push_exc(4'b0001, 2'd1, c + 2);
    tick(1);
    mask_we = 1'b0;
    service(4'b0010, e);
    irq = 4'b0000;
    tick(2);
`else
    // Without the mask option a mask write has no effect.
    c = cyc;
    mask_we = 1'b1;
    mask_wdata = 4'b0010;
    irq = 4'b0010;
    push_exc(4'b0001, 2'd1, c + 2);
    tick(1);
    mask_we = 1'b0;
    service(4'b0010, e);
    irq = 4'b0000;
    tick(2);
`endif

    // Reset in RAISE with irq[0] held high: exception abandoned, no new event.
    c = cyc;
    irq = 4'b0001;
    push_exc(4'b0001, 2'd0, c + 2);
    wait_exc();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    chk("rst_raise_outputs", {22'd0, exc, estatus, irq_id, irq_ack, double_fault, busy}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      seen = seen | exc | busy;
    end
    chk("rst_raise_no_event", {31'd0, seen}, 32'd0);
    irq = 4'b0000;
    tick(2);

    chk("exc_sb_empty", exc_sb.size(), 32'd0);
    chk("ack_sb_empty", ack_sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
